// File: rtl/elastic_pipe_register.sv
// Multi-stage valid/ready pipeline register with bubble collapsing and synchronous flush.
// in_ready is combinational from out_ready; all other outputs come straight from flops.
module elastic_pipe_register #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_LENGTH-1:0]         in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_LENGTH-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]       v_q, v_d;
  logic [WORD_LENGTH-1:0] d_q [DEPTH];
  logic [WORD_LENGTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [DEPTH:0]         rdy_c;

  // An empty stage is always ready, which packs words toward the output under stall.
  always_comb begin
    rdy_c        = '0;
    rdy_c[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      rdy_c[k] = !v_q[k] | rdy_c[k+1];
    end
  end

  assign in_ready = rdy_c[0] & !flush;

  // Stage advance; data only moves with a valid word so bubbles leave it stale.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy_c[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          d_d[0] = in_data;
        end
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy_c[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            d_d[k] = d_q[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Bench for elastic_pipe_register: DEPTH 1..4 instances share stimulus, each with its own scoreboard.
module tb_elastic_pipe_register;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic [3:0]       ir_v;
  logic [3:0]       ov_v;
  logic [3:0][31:0] od_v;
  logic [3:0][2:0]  occ_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar i = 0; i < 4; i++) begin : g_inst
    localparam int unsigned D = i + 1;
    logic                     ir, ov;
    logic [31:0]              od;
    logic [$clog2(D+1)-1:0]   occ_w;
    logic [31:0]              q[$];
    int                       occ_m = 0;
    int                       qlen = 0;

    elastic_pipe_register #(.WORD_LENGTH(32), .DEPTH(D)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
      .out_valid(ov), .out_ready(out_ready), .out_data(od),
      .occupancy(occ_w)
    );

    assign ir_v[i]  = ir;
    assign ov_v[i]  = ov;
    assign od_v[i]  = od;
    assign occ_v[i] = 3'(occ_w);

    // Transfers are decided by the stable pre-edge values sampled here.
    always @(negedge clk) begin
      if (!reset) begin
        q.delete();
        occ_m = 0;
      end else begin
        chk($sformatf("occ_d%0d", D), 32'(occ_w), 32'(occ_m));
        if (ov && out_ready) begin
          chk($sformatf("outq_nonempty_d%0d", D), 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            chk($sformatf("data_d%0d", D), od, q.pop_front());
            occ_m--;
          end
        end
        if (flush) begin
          q.delete();
          occ_m = 0;
        end else if (in_valid && ir) begin
          q.push_back(in_data);
          occ_m++;
        end
      end
      qlen = q.size();
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_ov", 32'(ov_v[1]), 32'd0);
    chk("rst_occ", 32'(occ_v[1]), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_ir", 32'(ir_v[1]), 32'd1);

    // 1: reset mid-stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 32'h71; tick();
    in_data = 32'h72; tick();
    in_data = 32'h73; tick();
    chk("t1_ov_before", 32'(ov_v[1]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_ov", 32'(ov_v[1]), 32'd0);
    chk("t1_od", od_v[1], 32'd0);
    chk("t1_occ", 32'(occ_v[1]), 32'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t1_ir", 32'(ir_v[1]), 32'd1);

    // 2: streaming, DEPTH=2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 32'h11; chk("t2_ir0", 32'(ir_v[1]), 32'd1); tick();
    in_data = 32'h22; chk("t2_ir1", 32'(ir_v[1]), 32'd1); chk("t2_ov1", 32'(ov_v[1]), 32'd0); tick();
    in_data = 32'h33; chk("t2_ir2", 32'(ir_v[1]), 32'd1); chk("t2_ov2", 32'(ov_v[1]), 32'd1);
    chk("t2_od2", od_v[1], 32'h11); tick();
    in_valid = 1'b0;
    chk("t2_od3", od_v[1], 32'h22); tick();
    chk("t2_od4", od_v[1], 32'h33); tick();
    chk("t2_ov5", 32'(ov_v[1]), 32'd0);
    drain();

    // 3: stall and release, DEPTH=2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 32'hA1; tick();
    in_data = 32'hA2; tick();
    in_data = 32'hA3;
    chk("t3_occ", 32'(occ_v[1]), 32'd2);
    chk("t3_ir_full", 32'(ir_v[1]), 32'd0);
    chk("t3_od_hold", od_v[1], 32'hA1);
    tick();
    chk("t3_occ_hold", 32'(occ_v[1]), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("t3_ir_release", 32'(ir_v[1]), 32'd1);
    chk("t3_od0", od_v[1], 32'hA1); tick();
    in_valid = 1'b0;
    chk("t3_occ_full_xfer", 32'(occ_v[1]), 32'd2);
    chk("t3_od1", od_v[1], 32'hA2); tick();
    chk("t3_od2", od_v[1], 32'hA3); tick();
    chk("t3_ov_end", 32'(ov_v[1]), 32'd0);
    drain();

    // 4: bubble collapse, DEPTH=3
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 32'h6; tick();
    in_valid = 1'b0; tick(); tick();
    chk("t4_occ", 32'(occ_v[2]), 32'd2);
    chk("t4_ov", 32'(ov_v[2]), 32'd1);
    chk("t4_od", od_v[2], 32'h5);
    chk("t4_ir", 32'(ir_v[2]), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("t4_od0", od_v[2], 32'h5); tick();
    chk("t4_ov1", 32'(ov_v[2]), 32'd1);
    chk("t4_od1", od_v[2], 32'h6); tick();
    chk("t4_ov2", 32'(ov_v[2]), 32'd0);
    drain();

    // 5: flush of a full pipe, DEPTH=2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 32'hB1; tick();
    in_data = 32'hB2; tick();
    in_data = 32'hB3;
    flush = 1'b1;
    #1;
    chk("t5_ir_flush", 32'(ir_v[1]), 32'd0);
    chk("t5_ov_flush", 32'(ov_v[1]), 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_ov", 32'(ov_v[1]), 32'd0);
    chk("t5_occ", 32'(occ_v[1]), 32'd0);
    out_ready = 1'b1;
    tick(); tick();
    chk("t5_not_taken", 32'(ov_v[1]), 32'd0);
    drain();

    // 6: random traffic on all depths
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = $urandom;
      tick();
    end
    drain();
    chk("t6_empty_d1", 32'(g_inst[0].qlen), 32'd0);
    chk("t6_empty_d2", 32'(g_inst[1].qlen), 32'd0);
    chk("t6_empty_d3", 32'(g_inst[2].qlen), 32'd0);
    chk("t6_empty_d4", 32'(g_inst[3].qlen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
